// File: rtl/multiplier.sv
// Pipelined unsigned multiplier returning the low DATA_LEN bits of a*b after PIPELINE_STAGE edges.
// Define MULTIPLIER_SATURATE_EN to clamp products that overflow DATA_LEN bits to all-ones.
`timescale 1ns/1ps
module multiplier #(
  parameter int DATA_LEN       = 32,
  parameter int PIPELINE_STAGE = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_LEN-1:0] a,
  input  logic [DATA_LEN-1:0] b,
  output logic [DATA_LEN-1:0] result
);

  localparam int LO = DATA_LEN / 2;
  localparam int HI = DATA_LEN - LO;

  // Upper product bits only matter when they can trigger saturation.
`ifdef MULTIPLIER_SATURATE_EN
  localparam int PW = 2 * DATA_LEN;
`else
  localparam int PW = DATA_LEN;
`endif

  function automatic logic [DATA_LEN-1:0] f_finalize(input logic [PW-1:0] full);
`ifdef MULTIPLIER_SATURATE_EN
    f_finalize = (|full[PW-1:DATA_LEN]) ? {DATA_LEN{1'b1}} : full[DATA_LEN-1:0];
`else
    f_finalize = full;
`endif
  endfunction

  generate
    if (PIPELINE_STAGE == 0) begin : g_comb
      logic [PW-1:0] w_full;
      assign w_full = PW'(a) * PW'(b);
      assign result = f_finalize(w_full);
    end else if (PIPELINE_STAGE == 1) begin : g_single
      logic [PW-1:0]       w_full;
      logic [DATA_LEN-1:0] r_result;
      assign w_full = PW'(a) * PW'(b);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_result <= '0;
        end else begin
          r_result <= f_finalize(w_full);
        end
      end

      assign result = r_result;
    end else begin : g_split
      logic [LO-1:0]       w_bLo;
      logic [HI-1:0]       w_bHi;
      logic [PW-1:0]       r_ppLo;
      logic [PW-1:0]       r_ppHi;
      logic [DATA_LEN-1:0] r_sum;

      assign w_bLo = b[LO-1:0];
      assign w_bHi = b[DATA_LEN-1:LO];

      // First stage forms two half-width partial products; second stage aligns and sums them.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_ppLo <= '0;
          r_ppHi <= '0;
        end else begin
          r_ppLo <= PW'(a) * PW'(w_bLo);
          r_ppHi <= PW'(a) * PW'(w_bHi);
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_sum <= '0;
        end else begin
          r_sum <= f_finalize(r_ppLo + (r_ppHi << LO));
        end
      end

      if (PIPELINE_STAGE == 2) begin : g_noDelay
        assign result = r_sum;
      end else begin : g_delay
        logic [DATA_LEN-1:0] r_delay [PIPELINE_STAGE-2];

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            for (int i = 0; i < PIPELINE_STAGE - 2; i++) begin
              r_delay[i] <= '0;
            end
          end else begin
            r_delay[0] <= r_sum;
            for (int i = 1; i < PIPELINE_STAGE - 2; i++) begin
              r_delay[i] <= r_delay[i-1];
            end
          end
        end

        assign result = r_delay[PIPELINE_STAGE-3];
      end
    end
  endgenerate

endmodule

// File: tb/tb_multiplier.sv
// Randomised self-checking bench for multiplier at PIPELINE_STAGE 0, 1, 2 and 4 against a plain-arithmetic model.
// Honours MULTIPLIER_SATURATE_EN when it is defined for the whole build.
`timescale 1ns/1ps
module tb_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] resultP0;
  logic [31:0] resultP1;
  logic [31:0] resultP2;
  logic [31:0] resultP4;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] hist[$];

`ifdef MULTIPLIER_SATURATE_EN
  localparam logic [31:0] EXP_BIG_SQ   = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_FFX2     = 32'hFFFF_FFFF;
  localparam logic [31:0] EXP_ONES_SQ  = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] EXP_BIG_SQ   = 32'h0000_0000;
  localparam logic [31:0] EXP_FFX2     = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_ONES_SQ  = 32'h0000_0001;
`endif

  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(0)) dutP0 (.clk(clk), .reset(reset), .a(a), .b(b), .result(resultP0));
  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(1)) dutP1 (.clk(clk), .reset(reset), .a(a), .b(b), .result(resultP1));
  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(2)) dutP2 (.clk(clk), .reset(reset), .a(a), .b(b), .result(resultP2));
  multiplier #(.DATA_LEN(32), .PIPELINE_STAGE(4)) dutP4 (.clk(clk), .reset(reset), .a(a), .b(b), .result(resultP4));

  always #5 clk = ~clk;

  function automatic logic [31:0] refModel(input logic [31:0] x, input logic [31:0] y);
    longint unsigned full;
    full = longint'(x) * longint'(y);
`ifdef MULTIPLIER_SATURATE_EN
    if (full > 64'h0000_0000_FFFF_FFFF) return 32'hFFFF_FFFF;
`endif
    return full[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clearHistory();
    hist = {};
    for (int i = 0; i < 4; i++) hist.push_back(32'h0);
  endtask

  // Drives one pair just after a falling edge, then checks every pipeline depth at the next falling edge.
  task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn);
    a = aIn;
    b = bIn;
    #1;
    checkOutput("comb_p0", resultP0, refModel(aIn, bIn));
    @(posedge clk);
    hist.push_front(refModel(aIn, bIn));
    void'(hist.pop_back());
    @(negedge clk);
    checkOutput("pipe_p1", resultP1, hist[0]);
    checkOutput("pipe_p2", resultP2, hist[1]);
    checkOutput("pipe_p4", resultP4, hist[3]);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    reset = 1'b0;
    a = 32'd6;
    b = 32'd7;
    clearHistory();
    #1;
    checkOutput("reset_p1", resultP1, 32'h0);
    checkOutput("reset_p2", resultP2, 32'h0);
    checkOutput("reset_p4", resultP4, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(32'd6, 32'd7);
    checkOutput("req22_before", resultP2, 32'h0);
    applyStimulus(32'd6, 32'd7);
    checkOutput("req22_after", resultP2, 32'd42);

    applyStimulus(32'h0001_0000, 32'h0001_0000);
    applyStimulus(32'd3, 32'd5);
    checkOutput("big_square", resultP2, EXP_BIG_SQ);
    applyStimulus(32'd100, 32'd200);
    checkOutput("b2b_15", resultP2, 32'd15);
    applyStimulus(32'hFFFF_FFFF, 32'd2);
    checkOutput("b2b_20000", resultP2, 32'd20000);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("b2b_ffx2", resultP2, EXP_FFX2);
    applyStimulus(32'd1, 32'hDEAD_BEEF);
    checkOutput("ones_square", resultP2, EXP_ONES_SQ);
    applyStimulus(32'h0, 32'h1234_5678);
    checkOutput("one_times_b", resultP2, 32'hDEAD_BEEF);
    applyStimulus(32'h8765_4321, 32'h0);
    checkOutput("zero_times_b", resultP2, 32'h0);
    applyStimulus(32'd0, 32'd0);
    checkOutput("a_times_zero", resultP2, 32'h0);

    a = 32'd9;
    b = 32'd9;
    #1;
    checkOutput("p0_comb_81", resultP0, 32'd81);

    // Capture (12,12), then pulse reset before the next rising edge: 144 must never surface.
    applyStimulus(32'd12, 32'd12);
    a = 32'd0;
    b = 32'd0;
    #1 reset = 1'b0;
    #0.5;
    checkOutput("req25_p1", resultP1, 32'h0);
    checkOutput("req25_p2", resultP2, 32'h0);
    checkOutput("req25_p4", resultP4, 32'h0);
    #0.5 reset = 1'b1;
    clearHistory();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(32'd0, 32'd0);
      checkOutput("req25_hold", resultP2, 32'h0);
    end

    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom_range(0, 65535); rb = $urandom_range(0, 65535); end
        2: begin ra = $urandom_range(0, 2); rb = $urandom; end
        default: begin ra = $urandom; rb = $urandom_range(0, 255); end
      endcase
      applyStimulus(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
